mem_issue_queue: RTL and testbench

MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

---
 rtl/mem_issue_queue_pkg.sv | 15 +
 rtl/mem_iq_fifo.sv | 43 ++++
 rtl/mem_issue_queue.sv | 99 +++++++++
 tb/tb_mem_issue_queue.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_issue_queue_pkg.sv
// mem_issue_queue_pkg: shared core constants for the memory issue queue (bhw codes, default tag width/latency, FSM states).
package mem_issue_queue_pkg;
  localparam int TAG_W_DEF = 5;
  localparam int LAT_DEF = 2;
  typedef enum logic [2:0] {
    BHW_B  = 3'b000,
    BHW_H  = 3'b001,
    BHW_W  = 3'b010,
    BHW_BU = 3'b100,
    BHW_HU = 3'b101
  } bhw_e;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/mem_iq_fifo.sv
// mem_iq_fifo: in-order storage for queued memory ops with wrapping pointers and occupancy count.
module mem_iq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = cnt_q == '0;
  // power-of-two depth lets the pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order memory op queue issuing one op at a time to a fixed-latency memory FU.
// Define MEM_IQ_BYPASS_EN to let an op arriving at an empty, free queue issue in its accept cycle.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = TAG_W_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mem_w,
  input  logic [2:0]             in_bhw,
  input  logic [31:0]            in_rs1,
  input  logic [31:0]            in_rs2,
  input  logic [31:0]            in_imm,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   fu_en,
  output logic                   fu_mem_w,
  output logic [2:0]             fu_bhw,
  output logic [31:0]            fu_rs1,
  output logic [31:0]            fu_rs2,
  output logic [31:0]            fu_imm,
  input  logic [31:0]            fu_data,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [TAG_W-1:0]       wb_tag,
  output logic [31:0]            wb_data,
  output logic                   wb_is_store,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = 100;
  localparam int W = FW + TAG_W;
  logic [W-1:0] in_ent, head, src;
  logic [FW-1:0] fu_q, fu_d;
  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic st_q, st_d, wbv_q, wbv_d;
  logic empty, accept, slot, issue_h, byp, issue, push, done;
  assign in_ent = {in_mem_w, in_bhw, in_rs1, in_rs2, in_imm, in_tag};
  assign in_ready = count < CW'(DEPTH);
  assign accept = state_q == ST_DONE && wb_ready;
  assign slot = state_q == ST_IDLE || accept;
  assign issue_h = slot && !empty && !flush;
`ifdef MEM_IQ_BYPASS_EN
  assign byp = rst && slot && empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif
  assign issue = issue_h || byp;
  assign push = in_valid && in_ready && !byp;
  assign src = byp ? in_ent : head;
  assign done = state_q == ST_BUSY && cnt_q == 3'd1;
  assign fu_en = issue;
  assign {fu_mem_w, fu_bhw, fu_rs1, fu_rs2, fu_imm} = issue ? src[W-1:TAG_W] : fu_q;
  assign wb_valid = wbv_q;
  assign wb_tag = tag_q;
  assign wb_data = data_q;
  assign wb_is_store = st_q;
  mem_iq_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(issue_h),
    .wdata(in_ent), .rdata(head), .count(count), .empty(empty)
  );
  // tag and store flag only change on issue, which in DONE requires acceptance first
  always_comb begin
    state_d = flush ? ST_IDLE : issue ? ST_BUSY : done ? ST_DONE : accept ? ST_IDLE : state_q;
    cnt_d = issue ? 3'(LAT) : state_q == ST_BUSY ? cnt_q - 3'd1 : cnt_q;
    fu_d = issue ? src[W-1:TAG_W] : fu_q;
    tag_d = issue ? src[TAG_W-1:0] : tag_q;
    st_d = issue ? src[W-1] : st_q;
    wbv_d = flush ? 1'b0 : done ? 1'b1 : accept ? 1'b0 : wbv_q;
    data_d = done ? (st_q ? 32'd0 : fu_data) : data_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      fu_q <= '0;
      tag_q <= '0;
      st_q <= 1'b0;
      wbv_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fu_q <= fu_d;
      tag_q <= tag_d;
      st_q <= st_d;
      wbv_q <= wbv_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue: scoreboard bench for mem_issue_queue in its default (no bypass) build.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_mem_w, fu_en, fu_mem_w, wb_valid, wb_ready, wb_is_store, flush;
  logic [2:0] in_bhw, fu_bhw;
  logic [31:0] in_rs1, in_rs2, in_imm, fu_rs1, fu_rs2, fu_imm, fu_data, wb_data;
  logic [TAG_W-1:0] in_tag, wb_tag;
  logic [$clog2(DEPTH):0] count;
  logic fu_mode;
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0] data;
    logic st;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  // memory model: fixed pattern or address sum; fu_* stay stable until the result is captured
  assign fu_data = fu_mode ? 32'hDEAD_BEEF : fu_rs1 + fu_imm;
  mem_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_w(in_mem_w), .in_bhw(in_bhw), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_tag(in_tag), .fu_en(fu_en), .fu_mem_w(fu_mem_w),
    .fu_bhw(fu_bhw), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_imm(fu_imm),
    .fu_data(fu_data), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_is_store(wb_is_store), .flush(flush), .count(count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [TAG_W-1:0] t, input logic w, input logic [31:0] rs1,
                      input logic [31:0] imm, input logic expect_wb, input logic [31:0] exp_data);
    in_valid = 1'b1;
    in_tag = t;
    in_mem_w = w;
    in_bhw = BHW_W;
    in_rs1 = rs1;
    in_rs2 = 32'h5;
    in_imm = imm;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 want 1 (tag %0d)", t);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (expect_wb) sb.push_back('{t, exp_data, w});
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got tag %0d want no writeback", wb_tag);
      end else begin
        e = sb.pop_front();
        chk("wb_tag", 32'(wb_tag), 32'(e.tag));
        chk("wb_data", wb_data, e.data);
        chk("wb_is_store", 32'(wb_is_store), 32'(e.st));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b0; in_valid = 1'b1; wb_ready = 1'b1; flush = 1'b0; fu_mode = 1'b1;
    in_mem_w = 1'b0; in_bhw = BHW_B; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_fu_en", 32'(fu_en), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_fu_rs1", fu_rs1, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_wb_valid", 32'(wb_valid), 0);
    @(posedge clk);
    #1;
    // single load: fu_en the cycle after accept, wb_valid LAT+1 cycles after fu_en
    push(3, 1'b0, 32'h100, 32'h4, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("load_fu_en", 32'(fu_en), 1);
    chk("load_fu_rs1", fu_rs1, 32'h100);
    chk("load_fu_imm", fu_imm, 32'h4);
    chk("load_fu_mem_w", 32'(fu_mem_w), 0);
    @(negedge clk);
    chk("load_fu_en_once", 32'(fu_en), 0);
    chk("load_fu_rs1_hold", fu_rs1, 32'h100);
    @(negedge clk);
    chk("load_wb_early", 32'(wb_valid), 0);
    @(negedge clk);
    chk("load_wb_valid", 32'(wb_valid), 1);
    @(negedge clk);
    chk("load_wb_drop", 32'(wb_valid), 0);
    @(posedge clk);
    #1;
    fu_mode = 1'b0;
    wb_ready = 1'b0;
    push(0, 1'b0, 32'h00, 32'h1, 1'b1, 32'h01);
    push(1, 1'b0, 32'h10, 32'h1, 1'b1, 32'h11);
    push(2, 1'b1, 32'h20, 32'h1, 1'b1, 32'h00);
    push(3, 1'b0, 32'h30, 32'h1, 1'b1, 32'h31);
    push(4, 1'b0, 32'h40, 32'h1, 1'b1, 32'h41);
    @(negedge clk);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_count", 32'(count), 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_wb_valid", 32'(wb_valid), 1);
      chk("bp_wb_tag", 32'(wb_tag), 0);
      chk("bp_wb_data", wb_data, 32'h01);
      chk("bp_no_fu_en", 32'(fu_en), 0);
    end
    @(posedge clk);
    #1 wb_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_fu_en", 32'(fu_en), 1);
    chk("bp_release_fu_rs1", fu_rs1, 32'h10);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !wb_valid) break;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_count", 32'(count), 0);
    @(posedge clk);
    #1;
    push(7, 1'b0, 32'h70, 32'h0, 1'b0, 32'h0);
    push(8, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
    push(9, 1'b1, 32'h90, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("flush_pre_count", 32'(count), 2);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_no_wb", 32'(wb_valid), 0);
      chk("flush_no_fu_en", 32'(fu_en), 0);
    end
    @(posedge clk);
    #1;
    push(10, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_mid_issue", 32'(fu_en), 1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_mid_no_wb", 32'(wb_valid), 0);
    end
    chk("rst_mid_count", 32'(count), 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
